// File: rtl/frog_game_state_pkg.sv
// Shared constants and state encoding for the Frog Ranck game-state controller.
package frog_game_state_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam int unsigned H_DISPLAY_DEF     = 640;
    localparam int unsigned PLAYER_WIDTH_DEF  = 32;
    localparam int unsigned PLAYER_HEIGHT_DEF = 32;
    localparam int unsigned CAR_WIDTH_DEF     = 64;
    localparam int unsigned CAR_HEIGHT_DEF    = 32;
    localparam int unsigned GOAL_Y_DEF        = 32;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/frog_game_state_rect_overlap.sv
// Combinational frog/car rectangle overlap test; sums are widened to 11 bits
// so nothing wraps, and rectangles that only touch do not overlap.
module rect_overlap #(
    parameter int unsigned H_DISPLAY     = 640,
    parameter int unsigned PLAYER_WIDTH  = 32,
    parameter int unsigned PLAYER_HEIGHT = 32,
    parameter int unsigned CAR_WIDTH     = 64,
    parameter int unsigned CAR_HEIGHT    = 32
) (
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] car_x,
    input  logic [9:0] car_y,
    output logic       overlap
);
    logic [10:0] px, py, cx, cy;

    assign px = {1'b0, player_x};
    assign py = {1'b0, player_y};
    assign cx = {1'b0, car_x};
    assign cy = {1'b0, car_y};

    assign overlap = (cx < 11'(H_DISPLAY))
                  && (px < cx + 11'(CAR_WIDTH))
                  && (cx < px + 11'(PLAYER_WIDTH))
                  && (py < cy + 11'(CAR_HEIGHT))
                  && (cy < py + 11'(PLAYER_HEIGHT));
endmodule

// File: rtl/frog_game_state.sv
// Frog Ranck game-state controller: per-frame collision/goal checks, lives,
// level, score and IDLE/PLAY/HIT/WIN/OVER sequencing. Option: FROG_INVINCIBLE_EN.
module frog_game_state
    import frog_game_state_pkg::*;
#(
    parameter int unsigned H_DISPLAY     = H_DISPLAY_DEF,
    parameter int unsigned PLAYER_WIDTH  = PLAYER_WIDTH_DEF,
    parameter int unsigned PLAYER_HEIGHT = PLAYER_HEIGHT_DEF,
    parameter int unsigned CAR_WIDTH     = CAR_WIDTH_DEF,
    parameter int unsigned CAR_HEIGHT    = CAR_HEIGHT_DEF,
    parameter int unsigned NUM_CARS      = 4,
    parameter int unsigned GOAL_Y        = GOAL_Y_DEF,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned HIT_FRAMES    = 60,
    parameter int unsigned WIN_FRAMES    = 60
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  frame_tick,
    input  logic                  start_btn,
    input  logic [9:0]            player_x,
    input  logic [9:0]            player_y,
    input  logic [10*NUM_CARS-1:0] car_x_flat,
    input  logic [10*NUM_CARS-1:0] car_y_flat,
    output logic [2:0]            state,
    output logic [2:0]            lives,
    output logic [3:0]            level,
    output logic [7:0]            score,
    output logic                  player_reset,
    output logic                  freeze,
    output logic                  hit_flag
);
    state_t           state_q, state_d;
    logic [2:0]       lives_q, lives_d;
    logic [3:0]       level_q, level_d;
    logic [7:0]       score_q, score_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             player_reset_q, player_reset_d;
    logic             hit_flag_q, hit_flag_d;
    logic             start_btn_q;
    logic             start_edge;
    logic [NUM_CARS-1:0] car_hit;
    logic             hit;

    genvar k;
    generate
        for (k = 0; k < NUM_CARS; k++) begin : g_car
            rect_overlap #(
                .H_DISPLAY    (H_DISPLAY),
                .PLAYER_WIDTH (PLAYER_WIDTH),
                .PLAYER_HEIGHT(PLAYER_HEIGHT),
                .CAR_WIDTH    (CAR_WIDTH),
                .CAR_HEIGHT   (CAR_HEIGHT)
            ) u_overlap (
                .player_x(player_x),
                .player_y(player_y),
                .car_x   (car_x_flat[10*k +: 10]),
                .car_y   (car_y_flat[10*k +: 10]),
                .overlap (car_hit[k])
            );
        end
    endgenerate

    assign hit        = |car_hit;
    assign start_edge = start_btn & ~start_btn_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= ST_IDLE;
            lives_q        <= '0;
            level_q        <= '0;
            score_q        <= '0;
            frame_cnt_q    <= '0;
            player_reset_q <= 1'b0;
            hit_flag_q     <= 1'b0;
            start_btn_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            score_q        <= score_d;
            frame_cnt_q    <= frame_cnt_d;
            player_reset_q <= player_reset_d;
            hit_flag_q     <= hit_flag_d;
            start_btn_q    <= start_btn;
        end
    end

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        level_d        = level_q;
        score_d        = score_q;
        frame_cnt_d    = frame_cnt_q;
        player_reset_d = 1'b0;
        hit_flag_d     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                // Start wins over frame_tick: no collision is checked this cycle.
                if (start_edge) begin
                    state_d        = ST_PLAY;
                    lives_d        = 3'(LIVES_INIT);
                    level_d        = 4'd1;
                    score_d        = '0;
                    frame_cnt_d    = '0;
                    player_reset_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (hit) begin
                        hit_flag_d = 1'b1;
`ifndef FROG_INVINCIBLE_EN
                        lives_d     = lives_q - 3'd1;
                        frame_cnt_d = CNT_W'(HIT_FRAMES);
                        state_d     = ST_HIT;
`endif
                    end else if ({1'b0, player_y} < 11'(GOAL_Y)) begin
                        if (score_q != '1)    score_d = score_q + 8'd1;
                        if (level_q != 4'd15) level_d = level_q + 4'd1;
                        frame_cnt_d = CNT_W'(WIN_FRAMES);
                        state_d     = ST_WIN;
                    end
                end
            end
            ST_HIT, ST_WIN: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q - 1'b1;
                    if (frame_cnt_q == CNT_W'(1)) begin
                        if (state_q == ST_HIT && lives_q == '0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d        = ST_PLAY;
                            player_reset_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state        = state_q;
        lives        = lives_q;
        level        = level_q;
        score        = score_q;
        player_reset = player_reset_q;
        hit_flag     = hit_flag_q;
        freeze       = (state_q != ST_PLAY);
    end

endmodule

// File: tb/tb_frog_game_state.sv
// Directed self-checking bench for frog_game_state (default build).
module tb_frog_game_state;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start_btn = 1'b0;
    logic [9:0]  player_x = '0;
    logic [9:0]  player_y = '0;
    logic [39:0] car_x_flat = '0;
    logic [39:0] car_y_flat = '0;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [3:0]  level;
    logic [7:0]  score;
    logic        player_reset;
    logic        freeze;
    logic        hit_flag;

    int total = 0;
    int bad   = 0;

    frog_game_state dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .player_x    (player_x),
        .player_y    (player_y),
        .car_x_flat  (car_x_flat),
        .car_y_flat  (car_y_flat),
        .state       (state),
        .lives       (lives),
        .level       (level),
        .score       (score),
        .player_reset(player_reset),
        .freeze      (freeze),
        .hit_flag    (hit_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    px, py, cx, cy, k;
        int    e_hit, e_state, e_lives, e_level, e_score;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic park_cars();
        for (int i = 0; i < 4; i++) begin
            car_x_flat[10*i +: 10] = 10'd700;
            car_y_flat[10*i +: 10] = 10'd320;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        start_btn = 1'b0;
        frame_tick = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic press_start();
        @(negedge CLK);
        start_btn = 1'b1;
        @(negedge CLK);
        start_btn = 1'b0;
    endtask

    task automatic tick();
        @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fresh_game();
        park_cars();
        player_x = 10'd200;
        player_y = 10'd320;
        do_reset();
        press_start();
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{"hit_basic",     200, 320, 180, 320, 0, 1, 2, 2, 1, 0};
        vecs[1]  = '{"touch_right",   200, 320, 232, 320, 0, 0, 1, 3, 1, 0};
        vecs[2]  = '{"touch_left",    200, 320, 136, 320, 0, 0, 1, 3, 1, 0};
        vecs[3]  = '{"touch_below",   200, 320, 200, 352, 0, 0, 1, 3, 1, 0};
        vecs[4]  = '{"partial_y",     200, 320, 210, 340, 1, 1, 2, 2, 1, 0};
        vecs[5]  = '{"goal",          200,  10, 400, 300, 0, 0, 3, 3, 2, 1};
        vecs[6]  = '{"goal_and_hit",  200,  10, 190,   0, 2, 1, 2, 2, 1, 0};
        vecs[7]  = '{"wrap_offscreen",  0, 320,1000, 320, 0, 0, 1, 3, 1, 0};
        vecs[8]  = '{"edge_x639",     620, 320, 639, 320, 0, 1, 2, 2, 1, 0};
        vecs[9]  = '{"car3_hit",      300, 200, 280, 210, 3, 1, 2, 2, 1, 0};
        vecs[10] = '{"goal_y31",      100,  31, 400, 300, 0, 0, 3, 3, 2, 1};
        vecs[11] = '{"goal_y32",      100,  32, 400, 300, 0, 0, 1, 3, 1, 0};

        // reset values
        park_cars();
        do_reset();
        @(negedge CLK);
        chk("rst_state", int'(state), 0);
        chk("rst_lives", int'(lives), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_preset", int'(player_reset), 0);
        chk("rst_hitflag", int'(hit_flag), 0);
        chk("rst_freeze", int'(freeze), 1);

        // start
        press_start();
        chk("start_state", int'(state), 1);
        chk("start_lives", int'(lives), 3);
        chk("start_level", int'(level), 1);
        chk("start_score", int'(score), 0);
        chk("start_preset", int'(player_reset), 1);
        chk("start_freeze", int'(freeze), 0);
        @(negedge CLK);
        chk("start_preset_drop", int'(player_reset), 0);

        // single-frame vectors, each from a fresh game
        for (int v = 0; v < 12; v++) begin
            fresh_game();
            player_x = 10'(vecs[v].px);
            player_y = 10'(vecs[v].py);
            car_x_flat[10*vecs[v].k +: 10] = 10'(vecs[v].cx);
            car_y_flat[10*vecs[v].k +: 10] = 10'(vecs[v].cy);
            tick();
            chk({vecs[v].name, "_hit"},   int'(hit_flag), vecs[v].e_hit);
            chk({vecs[v].name, "_state"}, int'(state),    vecs[v].e_state);
            chk({vecs[v].name, "_lives"}, int'(lives),    vecs[v].e_lives);
            chk({vecs[v].name, "_level"}, int'(level),    vecs[v].e_level);
            chk({vecs[v].name, "_score"}, int'(score),    vecs[v].e_score);
        end

        // hit freeze length, one-cycle hit_flag, start ignored in HIT
        fresh_game();
        car_x_flat[9:0] = 10'd180;
        tick();
        chk("seq_hit_flag", int'(hit_flag), 1);
        @(negedge CLK);
        chk("seq_hit_flag_drop", int'(hit_flag), 0);
        press_start();
        chk("seq_start_in_hit", int'(state), 2);
        chk("seq_start_in_hit_preset", int'(player_reset), 0);
        do_ticks(59);
        chk("seq_hit_59", int'(state), 2);
        chk("seq_hit_freeze", int'(freeze), 1);
        tick();
        chk("seq_hit_exit", int'(state), 1);
        chk("seq_hit_exit_preset", int'(player_reset), 1);
        chk("seq_hit_exit_freeze", int'(freeze), 0);

        // game over after two more hits
        tick();
        do_ticks(60);
        tick();
        chk("over_lives0", int'(lives), 0);
        do_ticks(59);
        chk("over_still_hit", int'(state), 2);
        tick();
        chk("over_state", int'(state), 4);
        chk("over_preset", int'(player_reset), 0);

        // start coinciding with frame_tick while overlapping; held button
        @(negedge CLK);
        start_btn = 1'b1;
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        chk("restart_state", int'(state), 1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_hit", int'(hit_flag), 0);
        pulses = int'(player_reset);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            pulses += int'(player_reset);
        end
        start_btn = 1'b0;
        chk("held_pulses", pulses, 1);
        chk("held_state", int'(state), 1);

        // win freeze
        fresh_game();
        player_y = 10'd10;
        tick();
        chk("win_state", int'(state), 3);
        player_y = 10'd320;
        do_ticks(59);
        chk("win_59", int'(state), 3);
        tick();
        chk("win_exit", int'(state), 1);
        chk("win_exit_preset", int'(player_reset), 1);
        chk("win_lives", int'(lives), 3);

        // level saturation
        fresh_game();
        player_y = 10'd10;
        for (int w = 0; w < 16; w++) begin
            tick();
            do_ticks(60);
        end
        chk("sat_level", int'(level), 15);
        chk("sat_score", int'(score), 16);

        // asynchronous reset mid-HIT
        fresh_game();
        car_x_flat[9:0] = 10'd180;
        tick();
        do_ticks(5);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_lives", int'(lives), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_score", int'(score), 0);
        chk("arst_freeze", int'(freeze), 1);
        chk("arst_hit", int'(hit_flag), 0);
        chk("arst_preset", int'(player_reset), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("arst_stays_idle", int'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
